// File: rtl/text_console_writer.sv
// Character-stream front end for the VGA text buffer: keeps a hardware cursor,
// interprets LF/CR/BS/FF and emits one {attr,char} cell write per cycle.
module text_console_writer #(
    parameter int unsigned COLS         = 100,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned ADDR_W       = 14,
    parameter logic [5:0]  DEFAULT_ATTR = 6'b111_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    input  logic              attr_we,
    input  logic [5:0]        attr_in,
    output logic              wenable,
    output logic [ADDR_W-1:0] waddr,
    output logic [13:0]       wdata,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, PUT_WRAP, CLEAR_ROW} state_t;

    state_t            state;
    logic [5:0]        attr;
    logic [5:0]        fill_attr;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] fill_last;
    logic [ADDR_W-1:0] row_base;

    logic              accept;
    logic              at_eol;
    logic              fill_done;
    logic [5:0]        next_y;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] cell_addr;

    // Cursor/row arithmetic shared by LF and line wrap
    always_comb begin
        accept    = in_valid && in_ready;
        at_eol    = (cursor_x == 7'(COLS - 1));
        fill_done = (fill_addr == fill_last);
        cell_addr = row_base + ADDR_W'(cursor_x);
        if (cursor_y == 6'(ROWS - 1)) begin
            next_y    = '0;
            next_base = '0;
        end else begin
            next_y    = cursor_y + 6'd1;
            next_base = row_base + ADDR_W'(COLS);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= CLEAR_ALL;
            attr      <= DEFAULT_ATTR;
            fill_attr <= DEFAULT_ATTR;
            fill_addr <= '0;
            fill_last <= ADDR_W'(CELLS - 1);
            row_base  <= '0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            wenable   <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            wenable <= 1'b0;
            if (attr_we) attr <= attr_in;

            case (state)
                CLEAR_ALL, PUT_WRAP, CLEAR_ROW: begin
                    wenable   <= 1'b1;
                    waddr     <= fill_addr;
                    wdata     <= {fill_attr, CH_SPACE};
                    fill_addr <= fill_addr + ADDR_W'(1);
                    in_ready  <= 1'b0;
                    busy      <= 1'b1;
                    if (fill_done)               state <= IDLE;
                    else if (state == PUT_WRAP)  state <= CLEAR_ROW;
                end

                IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (accept) begin
                        case (in_char)
                            CH_LF: begin
                                // First cell of the new row is written on the accept edge
                                cursor_x  <= '0;
                                cursor_y  <= next_y;
                                row_base  <= next_base;
                                wenable   <= 1'b1;
                                waddr     <= next_base;
                                wdata     <= {attr, CH_SPACE};
                                fill_attr <= attr;
                                fill_addr <= next_base + ADDR_W'(1);
                                fill_last <= next_base + ADDR_W'(COLS - 1);
                                state     <= CLEAR_ROW;
                                in_ready  <= 1'b0;
                                busy      <= 1'b1;
                            end
                            CH_CR: cursor_x <= '0;
                            CH_BS: begin
                                if (cursor_x != 7'd0) begin
                                    cursor_x <= cursor_x - 7'd1;
                                    wenable  <= 1'b1;
                                    waddr    <= cell_addr - ADDR_W'(1);
                                    wdata    <= {attr, CH_SPACE};
                                end
                            end
                            CH_FF: begin
                                cursor_x  <= '0;
                                cursor_y  <= '0;
                                row_base  <= '0;
                                wenable   <= 1'b1;
                                waddr     <= '0;
                                wdata     <= {attr, CH_SPACE};
                                fill_attr <= attr;
                                fill_addr <= ADDR_W'(1);
                                fill_last <= ADDR_W'(CELLS - 1);
                                state     <= CLEAR_ALL;
                                in_ready  <= 1'b0;
                                busy      <= 1'b1;
                            end
                            default: begin
                                wenable <= 1'b1;
                                waddr   <= cell_addr;
                                wdata   <= {attr, in_char};
                                if (at_eol) begin
                                    // Wrap: the new row is cleared after the char write
                                    cursor_x  <= '0;
                                    cursor_y  <= next_y;
                                    row_base  <= next_base;
                                    fill_attr <= attr;
                                    fill_addr <= next_base;
                                    fill_last <= next_base + ADDR_W'(COLS - 1);
                                    state     <= PUT_WRAP;
                                    in_ready  <= 1'b0;
                                    busy      <= 1'b1;
                                end else begin
                                    cursor_x <= cursor_x + 7'd1;
                                end
                            end
                        endcase
                    end
                end

                default: state <= CLEAR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: stimulus pushes expected cell
// writes, a negedge monitor pops and compares every observed write.
module tb_text_console_writer;

    localparam int COLS   = 100;
    localparam int ROWS   = 60;
    localparam int ADDR_W = 14;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_char = 8'h00;
    logic              attr_we = 1'b0;
    logic [5:0]        attr_in = 6'h00;
    logic              wenable;
    logic [ADDR_W-1:0] waddr;
    logic [13:0]       wdata;
    logic [6:0]        cursor_x;
    logic [5:0]        cursor_y;
    logic              busy;

    always #5 clock = ~clock;

    text_console_writer dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .attr_we  (attr_we),
        .attr_in  (attr_in),
        .wenable  (wenable),
        .waddr    (waddr),
        .wdata    (wdata),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    typedef struct packed {
        logic [13:0] a;
        logic [13:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [13:0] last_a   = '0;
    logic [13:0] last_d   = '0;
    logic [5:0]  m_attr   = 6'b111_000;
    int          mx = 0;
    int          my = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clock) begin
        if (wenable === 1'b1) begin
            n_writes++;
            last_a = waddr;
            last_d = wdata;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, expected none", waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (waddr !== mon_e.a || wdata !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL write: addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                             waddr, wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic push(input int a, input logic [13:0] d);
        wr_t e;
        e.a = 14'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_row(input int y);
        for (int i = 0; i < COLS; i++) push(y * COLS + i, {m_attr, 8'h20});
    endtask

    // Reference behaviour for one accepted character
    task automatic model(input logic [7:0] c);
        case (c)
            8'h0A: begin mx = 0; my = (my + 1) % ROWS; push_row(my); end
            8'h0D: mx = 0;
            8'h08: if (mx > 0) begin mx--; push(my * COLS + mx, {m_attr, 8'h20}); end
            8'h0C: begin
                mx = 0; my = 0;
                for (int i = 0; i < COLS * ROWS; i++) push(i, {m_attr, 8'h20});
            end
            default: begin
                push(my * COLS + mx, {m_attr, c});
                if (mx == COLS - 1) begin mx = 0; my = (my + 1) % ROWS; push_row(my); end
                else mx++;
            end
        endcase
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic we, input logic [5:0] na);
        int t = 0;
        while (!in_ready && t < 10000) begin step(); t++; end
        if (t >= 10000) check("ready_timeout", int'(in_ready), 1);
        model(c);
        in_char  = c;
        in_valid = 1'b1;
        attr_we  = we;
        attr_in  = na;
        if (we) m_attr = na;
        step();
        in_valid = 1'b0;
        attr_we  = 1'b0;
    endtask

    task automatic low_cycles(output int n);
        n = 0;
        while (!in_ready && n < 7000) begin n++; step(); end
    endtask

    task automatic check_reset();
        check("rst_wenable", int'(wenable), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_cursor_x", int'(cursor_x), 0);
        check("rst_cursor_y", int'(cursor_y), 0);
    endtask

    task automatic release_reset();
        int n;
        m_attr = 6'b111_000;
        mx = 0; my = 0;
        for (int i = 0; i < COLS * ROWS; i++) push(i, 14'h3820);
        reset = 1'b1;
        step();
        low_cycles(n);
        check("clear_all_cycles", n, 6000);
        check("post_clear_busy", int'(busy), 0);
        check("post_clear_x", int'(cursor_x), 0);
        check("post_clear_y", int'(cursor_y), 0);
        check("post_clear_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;

        repeat (3) step();
        check_reset();
        release_reset();

        // Attribute change takes effect on the accept after the one it arrives with
        send(8'h41, 1'b0, 6'h00);
        check("A_addr", int'(last_a), 0);
        check("A_data", int'(last_d), 'h3841);
        send(8'h42, 1'b1, 6'b010_001);
        check("B_addr", int'(last_a), 1);
        check("B_data", int'(last_d), 'h3842);
        send(8'h43, 1'b0, 6'h00);
        check("C_addr", int'(last_a), 2);
        check("C_data", int'(last_d), 'h1143);
        check("C_cursor_x", int'(cursor_x), 3);

        // Backspace at (5,3), then at column 0
        send(8'h0D, 1'b0, 6'h00);
        repeat (3) send(8'h0A, 1'b0, 6'h00);
        for (int i = 0; i < 5; i++) send(8'h61, 1'b0, 6'h00);
        check("pre_bs_x", int'(cursor_x), 5);
        check("pre_bs_y", int'(cursor_y), 3);
        send(8'h08, 1'b0, 6'h00);
        check("bs_addr", int'(last_a), 304);
        check("bs_data", int'(last_d), 'h1120);
        check("bs_x", int'(cursor_x), 4);
        check("bs_y", int'(cursor_y), 3);
        send(8'h0D, 1'b0, 6'h00);
        w0 = n_writes;
        send(8'h08, 1'b0, 6'h00);
        step();
        check("bs0_no_write", n_writes - w0, 0);
        check("bs0_x", int'(cursor_x), 0);
        check("bs0_y", int'(cursor_y), 3);
        check("bs0_ready", int'(in_ready), 1);

        // Wrap from the bottom-right cell
        repeat (56) send(8'h0A, 1'b0, 6'h00);
        repeat (99) send(8'h78, 1'b0, 6'h00);
        check("corner_x", int'(cursor_x), 99);
        check("corner_y", int'(cursor_y), 59);
        send(8'h5A, 1'b0, 6'h00);
        check("Z_addr", int'(last_a), 5999);
        check("Z_data", int'(last_d), 'h115A);
        low_cycles(n);
        check("wrap_low_cycles", n, 101);
        check("wrap_x", int'(cursor_x), 0);
        check("wrap_y", int'(cursor_y), 0);

        // LF at (17,10), then CR
        repeat (10) send(8'h0A, 1'b0, 6'h00);
        repeat (17) send(8'h6B, 1'b0, 6'h00);
        check("pre_lf_x", int'(cursor_x), 17);
        send(8'h0A, 1'b0, 6'h00);
        check("lf_x", int'(cursor_x), 0);
        check("lf_y", int'(cursor_y), 11);
        low_cycles(n);
        check("lf_low_cycles", n, 100);
        send(8'h71, 1'b0, 6'h00);
        w0 = n_writes;
        send(8'h0D, 1'b0, 6'h00);
        step();
        check("cr_no_write", n_writes - w0, 0);
        check("cr_x", int'(cursor_x), 0);
        check("cr_y", int'(cursor_y), 11);
        check("cr_ready", int'(in_ready), 1);

        // Form feed clears the whole screen with the current attribute
        send(8'h0C, 1'b0, 6'h00);
        low_cycles(n);
        check("ff_low_cycles", n, 6000);
        check("ff_x", int'(cursor_x), 0);
        check("ff_y", int'(cursor_y), 0);

        // Reset in the middle of a row clear
        w0 = n_writes;
        send(8'h0A, 1'b0, 6'h00);
        repeat (49) step();
        check("pre_abort_writes", n_writes - w0, 50);
        reset = 1'b0;
        exp_q.delete();
        step();
        check_reset();
        repeat (2) step();
        release_reset();

        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the text-mode VGA driver's text buffer. Accepts one 8-bit character code per handshake from the CPU I/O path and maintains a hardware cursor. Handles the control codes LF, CR, BS and FF, wrapping at the line end and the screen bottom. Emits single-cycle writes on the `wenable`/`waddr`/`wdata` port that the VGA driver's text buffer consumes, using the same 14-bit cell format {fg[2:0], bg[2:0], char[7:0]}.

## Interface
- `COLS`, default 100: text columns.
- `ROWS`, default 60: text rows.
- `ADDR_W`, default 14: text buffer address width.
- `DEFAULT_ATTR`, default 6'b111_000: reset attribute {fg, bg}, white on black.

- `clock`  in  1  system/CPU clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  block can accept a character this cycle.
- `in_char`  in  8  character code or control code.
- `attr_we`  in  1  load `attr_in` into the attribute register.
- `attr_in`  in  6  {fg[2:0], bg[2:0]}.
- `wenable`  out  1  text buffer write strobe, one cell per cycle.
- `waddr`  out  ADDR_W  cell address, y*COLS + x.
- `wdata`  out  14  {attr, char}.
- `cursor_x`  out  7  current column, 0..COLS-1.
- `cursor_y`  out  6  current row, 0..ROWS-1.
- `busy`  out  1  a clear sequence is in progress (equals ~`in_ready`).

## Operation
- FSM states:
  - CLEAR_ALL: fill every cell.
  - IDLE: accept characters.
  - PUT_WRAP: a printable character was written and the line wrapped.
  - CLEAR_ROW: fill one row.
- Reset, while `reset`=0:
  - state enters CLEAR_ALL with its fill counter at 0.
  - cursor = (0,0); attr = DEFAULT_ATTR.
  - `wenable`=0, `waddr`=0, `wdata`=0, `in_ready`=0, `busy`=1.
- `in_ready`=1 only in IDLE. A character is accepted when `in_valid` and `in_ready` are both 1.
- Handling of an accepted character:
  - 0x0A LF: x←0; y←y+1, wrapping ROWS-1→0; then CLEAR_ROW on the new y.
  - 0x0D CR: x←0. No write.
  - 0x08 BS: if x>0, x←x-1 and write {attr,0x20} at (x-1,y). If x=0, no-op with no write.
  - 0x0C FF: cursor←(0,0); then CLEAR_ALL.
  - Any other code is printable: write {attr,char} at (x,y).
    - If x<COLS-1, x←x+1 and stay in IDLE.
    - If x=COLS-1, x←0 and y advances exactly as for LF; go to PUT_WRAP, then CLEAR_ROW.
- Clear fill:
  - Value is {attr_latched,0x20}, where attr_latched is captured when the clear starts.
  - Addresses ascend by 1 per cycle.
  - CLEAR_ROW writes row_base..row_base+COLS-1. CLEAR_ALL writes 0..COLS*ROWS-1.
- Attribute register:
  - `attr_we` is honoured in every state.
  - A character accepted in the same cycle as `attr_we` uses the old attr; the new attr applies from the next accept.
  - A running clear is unaffected by `attr_we`.
- Address arithmetic:
  - Keep a row_base register that steps by COLS; a multiplier is not required.
  - Maximum address is COLS*ROWS-1 = 5999, which fits in ADDR_W.
  - No address ≥ COLS*ROWS is ever driven with `wenable`=1.
- Reset asserted mid-clear or mid-write aborts immediately. The next cycle shows reset values, and a full CLEAR_ALL restarts after release.

## Timing
- All outputs are registered.
- Accept at edge N:
  - The resulting write has `wenable`=1 in cycle N+1.
  - `cursor_x`/`cursor_y` show the new position in cycle N+1.
- `wenable` is a single-cycle pulse per cell; back-to-back printable accepts give a write on every cycle.
- LF accepted at N: clear writes in cycles N+1..N+COLS; `in_ready`=0 in those cycles; `in_ready`=1 at N+COLS+1.
- Wrapping printable accepted at N: char write at N+1, row clear at N+2..N+COLS+1, `in_ready`=1 at N+COLS+2.
- FF accepted at N: writes at N+1..N+COLS*ROWS; `in_ready`=1 at N+COLS*ROWS+1.
- After reset release (first edge with `reset`=1 is cycle 0):
  - writes to addresses 0..5999 occur in cycles 1..6000.
  - `in_ready` rises in cycle 6001.
- CR, BS at x=0, and non-wrapping printable characters keep `in_ready`=1 continuously.

## Test plan
- Reset then release → exactly 6000 consecutive writes, addr 0..5999, `wdata`=0x3820; then `in_ready`=1, cursor (0,0).
- Send 'A' (0x41), then `attr_we` with 6'b010_001 in the same cycle as 'B' → write addr 0 data 0x3841, then addr 1 data 0x3842; the next 'C' writes addr 2 data 0x1143.
- Cursor at (5,3), send BS → write addr 304 data {attr,0x20}, cursor (4,3). At (0,3), BS → no write, cursor unchanged.
- Cursor at (99,59), send 'Z' → write addr 5999; then 100 writes at addr 0..99 (row 0 wraps and clears); cursor (0,0); `in_ready` low for 101 cycles.
- LF at (17,10) → cursor (0,11); writes 1100..1199; CR → cursor x=0 with no write.
- Assert `reset` during the 50th cycle of a CLEAR_ROW → next cycle `wenable`=0 and outputs at reset values; after release a full 6000-write CLEAR_ALL repeats.
